forwarding_select_unit: RTL

Sequential forwarding-control unit for the 5-stage RISC-V pipeline: tracks the destination registers of in-flight instructions and produces the registered 3-bit operand select codes that drive the two EX-stage 5-to-1 operand forwarding muxes. It also raises the load-use stall and inserts the matching bubble. It is the producer side of the forwarding select interface; the muxes are the consumers.

---
 rtl/forwarding_select_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/forwarding_select_unit.sv
// Forwarding-control unit: tracks EX/MEM/WB destinations and registers the EX operand mux selects.
// Optional macro FWD_WB_LATE_BYPASS_EN enables the WB-late (011) bypass for read-before-write register files.
module forwarding_select_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_write_en,
  input  logic                  id_is_load,
  input  logic                  mem_busy,
  input  logic                  flush,
  output logic [SEL_W-1:0]      fwd_sel1,
  output logic [SEL_W-1:0]      fwd_sel2,
  output logic                  load_stall
);

  localparam logic [SEL_W-1:0] SEL_RF      = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EXMEM   = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEMWB   = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_WB_LATE = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_LOAD    = SEL_W'(4);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  wen;
    logic                  load;
  } entry_t;

  entry_t ex_q;
  entry_t mem_q;
`ifdef FWD_WB_LATE_BYPASS_EN
  entry_t wb_q;
`endif

  logic ex_hit1, ex_hit2;
  logic mem_hit1, mem_hit2;
  logic wb_hit1, wb_hit2;
  logic [SEL_W-1:0] next_sel1, next_sel2;
  entry_t id_entry;

  // x0 is hardwired zero, so a write to it is never a forwarding source.
  function automatic logic hit(input logic used, input logic [REG_ADDR_W-1:0] rs,
                               input entry_t e);
    return used && e.wen && (e.rd == rs) && (e.rd != '0);
  endfunction

  // Nearest producer wins: EX entry, then MEM entry, then WB entry.
  function automatic logic [SEL_W-1:0] sel_code(input logic ex_hit, input logic mem_hit,
                                                input logic mem_load, input logic wb_hit);
    if (ex_hit)       return SEL_EXMEM;
    else if (mem_hit) return mem_load ? SEL_LOAD : SEL_MEMWB;
    else if (wb_hit)  return SEL_WB_LATE;
    else              return SEL_RF;
  endfunction

  always_comb begin
    ex_hit1  = hit(id_use_rs1, id_rs1, ex_q);
    ex_hit2  = hit(id_use_rs2, id_rs2, ex_q);
    mem_hit1 = hit(id_use_rs1, id_rs1, mem_q);
    mem_hit2 = hit(id_use_rs2, id_rs2, mem_q);
`ifdef FWD_WB_LATE_BYPASS_EN
    wb_hit1  = hit(id_use_rs1, id_rs1, wb_q);
    wb_hit2  = hit(id_use_rs2, id_rs2, wb_q);
`else
    wb_hit1  = 1'b0;
    wb_hit2  = 1'b0;
`endif
    next_sel1 = sel_code(ex_hit1, mem_hit1, mem_q.load, wb_hit1);
    next_sel2 = sel_code(ex_hit2, mem_hit2, mem_q.load, wb_hit2);
  end

  // A load in EX cannot supply its data to the ID consumer next cycle; a bubble is needed.
  assign load_stall = !mem_busy && !flush && ex_q.load && (ex_hit1 || ex_hit2);

  always_comb begin
    id_entry      = '0;
    id_entry.rd   = id_rd;
    id_entry.wen  = id_write_en;
    id_entry.load = id_is_load;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
`ifdef FWD_WB_LATE_BYPASS_EN
      wb_q     <= '0;
`endif
      fwd_sel1 <= SEL_RF;
      fwd_sel2 <= SEL_RF;
    end else if (!mem_busy) begin
      mem_q <= ex_q;
`ifdef FWD_WB_LATE_BYPASS_EN
      wb_q  <= mem_q;
`endif
      // Flushed or stalled ID instruction does not enter EX; a bubble (wen=0) takes its place.
      if (flush || load_stall) begin
        ex_q     <= '0;
        fwd_sel1 <= SEL_RF;
        fwd_sel2 <= SEL_RF;
      end else begin
        ex_q     <= id_entry;
        fwd_sel1 <= next_sel1;
        fwd_sel2 <= next_sel2;
      end
    end
  end

  sel1_legal: assert property (@(posedge clk) disable iff (!reset) fwd_sel1 <= SEL_LOAD);
  sel2_legal: assert property (@(posedge clk) disable iff (!reset) fwd_sel2 <= SEL_LOAD);
  stall_quiet: assert property (@(posedge clk) disable iff (!reset)
                                load_stall |-> (!flush && !mem_busy));

endmodule
